retire_trace_fifo: RTL
======================

# retire_trace_fifo

Retirement trace buffer that sits directly downstream of the single-cycle RISC-V core. It captures one record per retired instruction (PC, instruction word, destination-register write) into a FIFO for a host, UART dumper or bench to drain. It also owns run control for directed program tests: it detects the self-loop halt instruction, enforces a cycle budget, and raises a sticky `done`.

## Interface

Parameters:

- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `MAX_CYCLES`, 50: cycle budget after reset release before timeout.
- `HALT_INSTR`, 32'h0000006F: halt encoding (`jal x0, 0`).
- `HALT_MIN_CYCLES`, 6: halt is ignored while `cycle_count` < this value.

Ports:

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low.
- `ret_valid`  in  1  core retires an instruction this cycle.
- `ret_pc`  in  32  PC of the retiring instruction.
- `ret_instr`  in  32  instruction word.
- `ret_rd_we`  in  1  register-file write enable.
- `ret_rd`  in  5  destination register.
- `ret_rd_data`  in  32  write-back data.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_pc`, `out_instr`, `out_rd_data`  out  32 each  head entry fields.
- `out_rd`  out  5  head entry destination register.
- `out_rd_we`  out  1  head entry write flag.
- `count`  out  clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: at least one record was dropped.
- `dropped`  out  16  dropped-record count, saturating at 16'hFFFF.
- `cycle_count`  out  16  cycles spent in RUN, saturating.
- `halted`  out  1  sticky: halt was detected.
- `timeout`  out  1  sticky: the cycle budget expired.
- `done`  out  1  `halted | timeout`.

## Operation

- **State machine:** RUN → HALTED or RUN → TIMEOUT. HALTED and TIMEOUT are terminal until reset.
- **Cycle counter:** `cycle_count` increments every cycle in RUN and freezes on leaving RUN.
- **Halt:** in RUN, `ret_valid && ret_instr == HALT_INSTR && cycle_count >= HALT_MIN_CYCLES` moves the state to HALTED. The halt record itself is enqueued under the normal push rules.
- **Timeout:** in RUN, `cycle_count == MAX_CYCLES-1` with no halt in that cycle moves the state to TIMEOUT.
- **Halt and timeout in the same cycle:** HALTED wins; `timeout` stays 0.
- **Push:** occurs when `ret_valid` is high, state is RUN, and the FIFO is not full or a pop happens in the same cycle. A full FIFO therefore accepts simultaneous push and pop.
- **Stored write flag:** `ret_rd_we && ret_rd != 0`. Writes to x0 are recorded with `out_rd_we = 0`.
- **Drop:** `ret_valid` in RUN while full and not popping. The record is discarded, `overflow` is set, and `dropped` increments.
- **Outside RUN:** `ret_valid` is ignored and nothing is counted as dropped.
- **Pop:** `out_valid && out_ready`. Draining continues in every state. `out_ready` while empty has no effect.
- **Pointers:** read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. `count` tracks occupancy, with 0 meaning empty and DEPTH meaning full.
- **Output fields:** first-word fall-through from the head entry. Fields hold their values while `out_valid && !out_ready`, and are don't-care while `out_valid = 0`.

## Timing

- **Reset values (reset low at an edge):** state RUN, pointers 0, `count` 0, `out_valid` 0, `overflow` 0, `dropped` 0, `cycle_count` 0, `halted`/`timeout`/`done` 0. FIFO storage is not cleared.
- **Reset mid-operation:** takes effect at the same edge and discards all queued entries.
- **Push latency:** a record pushed at edge N gives `out_valid` = 1 and visible fields after edge N, i.e. one cycle.
- **Pop latency:** a pop at edge N presents the next entry after edge N. Back-to-back push and pop sustain one record per cycle.
- **Flag timing:** `halted`/`timeout`/`done` rise the cycle after the triggering edge, and `cycle_count` freezes at the same edge.
  - Halt example: a qualifying halt sampled at edge N gives `done` = 1 after N.
  - Timeout example: with no halt, `timeout` rises after the edge where `cycle_count` = MAX_CYCLES-1, so the final `cycle_count` is MAX_CYCLES-1.
- **Combinational paths:** none from any input to any output except `out_valid`/fields, which depend only on registered state.

## Test plan

- **Basic capture:** push 3 records (PC 0x0/0x4/0x8, rd x1/x2/x0, we 1) with `out_ready` = 0 → `count` = 3. Raise `out_ready` → entries come out in order, the third with `out_rd_we` = 0, and `count` returns to 0.
- **Overflow (DEPTH = 16):** push 18 records with no pop → `count` = 16, `overflow` = 1, `dropped` = 2. Draining returns the first 16 PCs in order.
- **Push/pop while full:** full FIFO, `ret_valid` and `out_ready` both high for 4 cycles → `count` stays 16 and `dropped` stays 0.
- **Early halt:** `HALT_INSTR` retired at `cycle_count` = 3 → ignored as a halt but enqueued. `HALT_INSTR` again at `cycle_count` = 8 → `halted` = 1, `done` = 1, `cycle_count` frozen at 9, and later `ret_valid` neither enqueues nor drops.
- **Timeout:** no halt, MAX_CYCLES = 50 → `timeout` = 1 after `cycle_count` reaches 49, `halted` = 0. Halt at the same cycle 49 → `halted` = 1, `timeout` = 0.
- **Reset mid-run:** reset low for 1 cycle with `count` = 5 and `overflow` = 1 → all outputs at reset values; the next push appears after one edge.

Source files
------------

// File: rtl/retire_trace_fifo_if.sv
// rtl/retire_trace_fifo_if.sv - retirement record and trace drain handshake bundle
//
// Purpose: groups the core-side retirement signals (ret_*) and the
// consumer-side drain handshake (out_*) of the retirement trace buffer.
//
// Modports:
//   master - environment side: drives ret_* and out_ready, observes out_*.
//   slave  - trace buffer side: observes ret_* and out_ready, drives out_*.
//
// Signals:
//   ret_valid    core retires an instruction this cycle
//   ret_pc       PC of the retiring instruction
//   ret_instr    instruction word
//   ret_rd_we    register-file write enable
//   ret_rd       destination register
//   ret_rd_data  write-back data
//   out_valid    head entry available
//   out_ready    consumer accepts the head entry
//   out_pc, out_instr, out_rd_data, out_rd, out_rd_we  head entry fields
interface retire_trace_fifo_if;
  logic        ret_valid;
  logic [31:0] ret_pc;
  logic [31:0] ret_instr;
  logic        ret_rd_we;
  logic [4:0]  ret_rd;
  logic [31:0] ret_rd_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_rd_data;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  modport master (
    output ret_valid, ret_pc, ret_instr, ret_rd_we, ret_rd, ret_rd_data,
    output out_ready,
    input  out_valid, out_pc, out_instr, out_rd_data, out_rd, out_rd_we
  );

  modport slave (
    input  ret_valid, ret_pc, ret_instr, ret_rd_we, ret_rd, ret_rd_data,
    input  out_ready,
    output out_valid, out_pc, out_instr, out_rd_data, out_rd, out_rd_we
  );
endinterface

// File: rtl/retire_trace_fifo.sv
// rtl/retire_trace_fifo.sv - retirement trace FIFO with halt/timeout run control
//
// Purpose: captures one record per retired instruction into a first-word
// fall-through FIFO and owns run control for directed program tests
// (self-loop halt detection, cycle budget, sticky done).
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-low
//   trace        retire_trace_fifo_if.slave: ret_* capture, out_* drain
//   count        current FIFO occupancy (0 = empty, DEPTH = full)
//   overflow     sticky, at least one record was dropped
//   dropped      dropped-record count, saturating
//   cycle_count  cycles spent in RUN, saturating
//   halted       sticky, halt instruction detected
//   timeout      sticky, cycle budget expired
//   done         halted | timeout
module retire_trace_fifo #(
  parameter int          DEPTH           = 16,
  parameter int          MAX_CYCLES      = 50,
  parameter logic [31:0] HALT_INSTR      = 32'h0000006F,
  parameter int          HALT_MIN_CYCLES = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  retire_trace_fifo_if.slave      trace,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [15:0]             dropped,
  output logic [15:0]             cycle_count,
  output logic                    halted,
  output logic                    timeout,
  output logic                    done
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [15:0]     HALT_MIN   = 16'(HALT_MIN_CYCLES);
  localparam logic [15:0]     LAST_CYCLE = 16'(MAX_CYCLES - 1);
  localparam logic [15:0]     SAT16      = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // FIFO storage, one array per record field; not cleared by reset.
  logic [31:0] mem_pc      [DEPTH];
  logic [31:0] mem_instr   [DEPTH];
  logic [31:0] mem_rd_data [DEPTH];
  logic [4:0]  mem_rd      [DEPTH];
  logic        mem_rd_we   [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic run;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;
  logic halt_hit;
  logic budget_hit;

  // ---------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------
  assign run   = (state == ST_RUN);
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign pop   = !empty && trace.out_ready;

  // Early halts are ignored so a halt encoding reached before the program
  // has had time to start does not end the test.
  assign halt_hit = run && trace.ret_valid &&
                    (trace.ret_instr == HALT_INSTR) &&
                    (cycle_count >= HALT_MIN);

  // Halt wins over an expiring budget in the same cycle.
  assign budget_hit = run && (cycle_count == LAST_CYCLE) && !halt_hit;

  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push = run && trace.ret_valid && (!full || pop);
  assign drop = run && trace.ret_valid && full && !pop;

  // ---------------------------------------------------------------------
  // Run-control FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Run-control FSM: next state. HALTED and TIMEOUT hold until reset.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (halt_hit) begin
          state_next = ST_HALTED;
        end else if (budget_hit) begin
          state_next = ST_TIMEOUT;
        end
      end
      default: state_next = state;
    endcase
  end

  // Run-control FSM: outputs
  always_comb begin
    halted  = 1'b0;
    timeout = 1'b0;
    case (state)
      ST_HALTED:  halted  = 1'b1;
      ST_TIMEOUT: timeout = 1'b1;
      default: ;
    endcase
    done = halted | timeout;
  end

  // ---------------------------------------------------------------------
  // Cycle counter: counts in RUN, but the edge that expires the budget
  // leaves it at the budget's last value so the final count reads
  // MAX_CYCLES-1. A halting edge still counts its own cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (run && !budget_hit && (cycle_count != SAT16)) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO storage write
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]      <= trace.ret_pc;
      mem_instr[wr_ptr]   <= trace.ret_instr;
      mem_rd_data[wr_ptr] <= trace.ret_rd_data;
      mem_rd[wr_ptr]      <= trace.ret_rd;
      // x0 writes are architecturally discarded, so record them as no-write.
      mem_rd_we[wr_ptr]   <= trace.ret_rd_we && (trace.ret_rd != 5'd0);
    end
  end

  // ---------------------------------------------------------------------
  // Pointers and occupancy; pointers wrap modulo DEPTH by width.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Drop accounting
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
      dropped  <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropped != SAT16) begin
        dropped <= dropped + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // First-word fall-through head presentation
  // ---------------------------------------------------------------------
  assign trace.out_valid   = !empty;
  assign trace.out_pc      = mem_pc[rd_ptr];
  assign trace.out_instr   = mem_instr[rd_ptr];
  assign trace.out_rd_data = mem_rd_data[rd_ptr];
  assign trace.out_rd      = mem_rd[rd_ptr];
  assign trace.out_rd_we   = mem_rd_we[rd_ptr];

endmodule
